// File: rtl/uart_tx_frame.sv
// UART frame transmitter: start bit, LSB-first data, optional parity, one stop bit.
// Outputs are registered from the next-state decode so TX_OUT and busy track the state register.
module uart_tx_frame #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  EN,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  busy
);

  localparam int unsigned TW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IW =
    (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] I_LAST = IW'(DATA_WIDTH - 1);
  localparam logic [TW-1:0] T_ONE  = TW'(1);
  localparam logic [IW-1:0] I_ONE  = IW'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                  state;
  state_t                  state_n;
  logic [TW-1:0]           timer;
  logic [TW-1:0]           timer_n;
  logic [IW-1:0]           index;
  logic [IW-1:0]           index_n;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH-1:0]   data_n;
  logic                    par_en;
  logic                    par_en_n;
  logic                    par_typ;
  logic                    par_typ_n;
  logic                    tx_n;
  logic                    busy_n;
  logic                    bit_done;

  assign bit_done = (timer == T_LAST);

  always_comb begin
    state_n   = state;
    timer_n   = timer;
    index_n   = index;
    data_n    = data;
    par_en_n  = par_en;
    par_typ_n = par_typ;
    if (!EN) begin
      state_n = IDLE;
      timer_n = '0;
      index_n = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (Data_Valid) begin
            data_n    = P_DATA;
            par_en_n  = PAR_EN;
            par_typ_n = PAR_TYP;
            timer_n   = '0;
            index_n   = '0;
            state_n   = START;
          end
        end
        START: begin
          if (bit_done) begin
            timer_n = '0;
            index_n = '0;
            state_n = DATA;
          end else begin
            timer_n = timer + T_ONE;
          end
        end
        DATA: begin
          if (bit_done) begin
            timer_n = '0;
            if (index == I_LAST) begin
              index_n = '0;
              state_n = par_en ? PARITY : STOP;
            end else begin
              index_n = index + I_ONE;
            end
          end else begin
            timer_n = timer + T_ONE;
          end
        end
        PARITY: begin
          if (bit_done) begin
            timer_n = '0;
            state_n = STOP;
          end else begin
            timer_n = timer + T_ONE;
          end
        end
        STOP: begin
          if (bit_done) begin
            timer_n = '0;
            state_n = IDLE;
          end else begin
            timer_n = timer + T_ONE;
          end
        end
        default: begin
          timer_n = '0;
          index_n = '0;
          state_n = IDLE;
        end
      endcase
    end
  end

  // Line level for the state we are entering, so it lands with the state.
  always_comb begin
    tx_n   = 1'b1;
    busy_n = 1'b0;
    unique case (state_n)
      IDLE: begin
        tx_n   = 1'b1;
        busy_n = 1'b0;
      end
      START: begin
        tx_n   = 1'b0;
        busy_n = 1'b1;
      end
      DATA: begin
        tx_n   = data_n[index_n];
        busy_n = 1'b1;
      end
      PARITY: begin
        tx_n   = (^data_n) ^ par_typ_n;
        busy_n = 1'b1;
      end
      STOP: begin
        tx_n   = 1'b1;
        busy_n = 1'b1;
      end
      default: begin
        tx_n   = 1'b1;
        busy_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      timer   <= '0;
      index   <= '0;
      data    <= '0;
      par_en  <= 1'b0;
      par_typ <= 1'b0;
      TX_OUT  <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      index   <= index_n;
      data    <= data_n;
      par_en  <= par_en_n;
      par_typ <= par_typ_n;
      TX_OUT  <= tx_n;
      busy    <= busy_n;
    end
  end

endmodule
